branch_predict_unit: RTL and testbench
======================================

Name: branch_predict_unit

Overview:
Dynamic branch predictor and misprediction resolver for the 5-stage RISC-V pipeline. It holds a direct-mapped branch history table (BHT) of N-bit saturating counters. The table is looked up with the IF-stage PC, and the entry is updated when a B-type branch resolves at EX/MEM. On resolution the block raises the pipeline flush and selects the PC recovery path. It also keeps saturating branch and mispredict statistics counters.

Parameters:
PC_W, 32, PC width in bits
IDX_W, 6, BHT index width; table depth = 2**IDX_W entries; index = pc[IDX_W+1:2]
CNT_W, 2, saturating counter width per entry (minimum 1)
INIT_CNT, 1, reset value of every counter (weakly not-taken for CNT_W=2)
PERF_W, 16, width of the statistics counters

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  synchronous reset, active-low
pc_if  input  PC_W  PC of the instruction in IF, used for lookup
predict_taken  output  1  prediction for pc_if; MSB of the indexed counter (combinational read)
resolve_valid  input  1  EX/MEM holds a valid instruction this cycle
resolve_opcode  input  7  opcode of the EX/MEM instruction
resolve_pc  input  PC_W  PC of the EX/MEM instruction
take_branch  input  1  actual branch outcome computed in EX
prediction_checkout_ex_mem  input  1  prediction carried down the pipeline with this branch
clear  output  1  flush IF/ID/EX and the jump-delay flops
pc_restore  output  1  1 = redirect the PC to the sequential path (resolve_pc+4); 0 = use the branch target
mispredict_cnt  output  PERF_W  count of resolved B-type mispredictions, saturating
branch_cnt  output  PERF_W  count of resolved B-type branches, saturating

Behaviour:
- A resolve event is resolve_valid=1 and resolve_opcode=7'b1100011. All other opcodes, or resolve_valid=0, cause no update, clear=0 and pc_restore=0.
- Lookup: predict_taken = bht[pc_if[IDX_W+1:2]][CNT_W-1]. Combinational, zero latency.
- Resolution outputs are combinational in the same cycle as the resolve event:
  - clear = event & (take_branch != prediction_checkout_ex_mem).
  - pc_restore = event & prediction_checkout_ex_mem & ~take_branch.
  - The predicted not-taken / actually taken case gives clear=1, pc_restore=0 (redirect to the target).
- BHT update happens at the clock edge ending an event cycle, on entry resolve_pc[IDX_W+1:2]:
  - take_branch=1: counter+1, saturating at 2**CNT_W-1.
  - take_branch=0: counter-1, saturating at 0.
  - Only one entry is written per cycle.
- Read/write collision: if the pc_if index equals the updating index in the same cycle, predict_taken reflects the pre-update value. There is no bypass. The new value is visible from the next cycle.
- Statistics, updated at the clock edge:
  - branch_cnt +1 per event.
  - mispredict_cnt +1 per event with clear=1.
  - Both saturate at 2**PERF_W-1 and never wrap.
- Reset (rst_n=0 at an edge):
  - Every BHT entry is set to INIT_CNT.
  - branch_cnt and mispredict_cnt are set to 0.
  - Reset takes priority over a simultaneous resolve event; that event's update is dropped.
  - clear and pc_restore remain combinational functions of the inputs during reset and are not forced to 0.
- Aliasing: PCs sharing the index bits share one entry. No tags are kept.
- Back-to-back events on consecutive cycles are each applied in order. An event on the same entry in the next cycle sees the already-updated counter.
- Implementation: BHT as a register array, so the reset clears the whole table in one cycle. No FSM beyond the per-entry counters.

Test Plan:
- Reset, then sweep pc_if across all 64 indices -> predict_taken=0 everywhere (INIT_CNT=1); branch_cnt=0, mispredict_cnt=0.
- Three resolve events at resolve_pc=0x40 with take_branch=1 and prediction_checkout_ex_mem=0,1,1:
  - First event: clear=1, pc_restore=0.
  - Second and third events: clear=0.
  - Entry 16 then reads counter 3; predict_taken=1 for pc_if=0x40 from the cycle after the first update.
  - mispredict_cnt=1, branch_cnt=3.
- Entry at counter 3, event with take_branch=0 and prediction_checkout_ex_mem=1 -> clear=1, pc_restore=1; counter becomes 2 and predict_taken stays 1. A second not-taken event -> counter 1, predict_taken=0. Four further not-taken events leave the counter at 0 (saturation).
- Collision: pc_if=0x80 while resolving 0x80 taken from counter 1 -> predict_taken=0 in that cycle, 1 in the next.
- resolve_opcode=7'b1101111 (JAL) with take_branch != prediction_checkout_ex_mem -> clear=0, pc_restore=0, no BHT or counter change. Same result for resolve_valid=0 with opcode 1100011.
- PERF_W=4 build: 20 mispredicting events -> mispredict_cnt holds at 15. rst_n low during an event -> table returns to INIT_CNT and both counters return to 0.

Source files
------------

// File: rtl/branch_predict_unit.sv
// Branch history table of saturating counters with misprediction flush/restore
// and saturating branch / mispredict statistics.
module branch_predict_unit #(
   parameter int PC_W     = 32,
   parameter int IDX_W    = 6,
   parameter int CNT_W    = 2,
   parameter int INIT_CNT = 1,
   parameter int PERF_W   = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [PC_W-1:0]   pc_if,
   output logic              predict_taken,
   input  logic              resolve_valid,
   input  logic [6:0]        resolve_opcode,
   input  logic [PC_W-1:0]   resolve_pc,
   input  logic              take_branch,
   input  logic              prediction_checkout_ex_mem,
   output logic              clear,
   output logic              pc_restore,
   output logic [PERF_W-1:0] mispredict_cnt,
   output logic [PERF_W-1:0] branch_cnt
);

   localparam int              DEPTH     = 1 << IDX_W;
   localparam logic [6:0]      OP_BRANCH = 7'b1100011;
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(INIT_CNT);
   localparam logic [PERF_W-1:0] PERF_MAX = '1;

   logic [DEPTH-1:0][CNT_W-1:0] bht_q, bht_d;
   logic [PERF_W-1:0]           branch_cnt_q, branch_cnt_d;
   logic [PERF_W-1:0]           mispredict_cnt_q, mispredict_cnt_d;

   logic             res_event;
   logic [IDX_W-1:0] idx_if, idx_res;
   logic [CNT_W-1:0] cur_cnt, nxt_cnt;

   assign res_event = resolve_valid & (resolve_opcode == OP_BRANCH);
   assign idx_if    = pc_if[IDX_W+1:2];
   assign idx_res   = resolve_pc[IDX_W+1:2];

   // Lookup reads the registered table only, so a same-cycle update is not bypassed.
   assign predict_taken = bht_q[idx_if][CNT_W-1];

   assign clear      = res_event & (take_branch != prediction_checkout_ex_mem);
   assign pc_restore = res_event & prediction_checkout_ex_mem & ~take_branch;

   assign cur_cnt = bht_q[idx_res];

   always_comb begin
      nxt_cnt = cur_cnt;
      if (take_branch) begin
         if (cur_cnt != CNT_MAX) nxt_cnt = cur_cnt + 1'b1;
      end else begin
         if (cur_cnt != '0) nxt_cnt = cur_cnt - 1'b1;
      end
   end

   always_comb begin
      bht_d            = bht_q;
      branch_cnt_d     = branch_cnt_q;
      mispredict_cnt_d = mispredict_cnt_q;
      if (res_event) begin
         bht_d[idx_res] = nxt_cnt;
         if (branch_cnt_q != PERF_MAX) branch_cnt_d = branch_cnt_q + 1'b1;
         if (clear && (mispredict_cnt_q != PERF_MAX))
            mispredict_cnt_d = mispredict_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bht_q            <= {DEPTH{CNT_INIT}};
         branch_cnt_q     <= '0;
         mispredict_cnt_q <= '0;
      end else begin
         bht_q            <= bht_d;
         branch_cnt_q     <= branch_cnt_d;
         mispredict_cnt_q <= mispredict_cnt_d;
      end
   end

   assign branch_cnt     = branch_cnt_q;
   assign mispredict_cnt = mispredict_cnt_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Bench for branch_predict_unit: directed plan then random traffic against a
// counter-table model; a PERF_W=4 copy shares the inputs to exercise saturation.
module tb_branch_predict_unit;

   localparam logic [6:0] OP_BR  = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] pc_if, resolve_pc;
   logic        resolve_valid, take_branch, pred_in;
   logic [6:0]  resolve_opcode;

   logic        pt_a, clr_a, pr_a;
   logic [15:0] mc_a, bc_a;
   logic        pt_b, clr_b, pr_b;
   logic [3:0]  mc_b, bc_b;

   int bht [64];
   int br_model, mp_model;
   int checks, errors;

   always #5 clk = ~clk;

   branch_predict_unit #(.PERF_W(16)) dut_a (
      .clk(clk), .rst_n(rst_n), .pc_if(pc_if), .predict_taken(pt_a),
      .resolve_valid(resolve_valid), .resolve_opcode(resolve_opcode),
      .resolve_pc(resolve_pc), .take_branch(take_branch),
      .prediction_checkout_ex_mem(pred_in), .clear(clr_a), .pc_restore(pr_a),
      .mispredict_cnt(mc_a), .branch_cnt(bc_a)
   );

   branch_predict_unit #(.PERF_W(4)) dut_b (
      .clk(clk), .rst_n(rst_n), .pc_if(pc_if), .predict_taken(pt_b),
      .resolve_valid(resolve_valid), .resolve_opcode(resolve_opcode),
      .resolve_pc(resolve_pc), .take_branch(take_branch),
      .prediction_checkout_ex_mem(pred_in), .clear(clr_b), .pc_restore(pr_b),
      .mispredict_cnt(mc_b), .branch_cnt(bc_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int sat(input int v, input int mx);
      return (v > mx) ? mx : v;
   endfunction

   task automatic model_reset();
      foreach (bht[i]) bht[i] = 1;
      br_model = 0;
      mp_model = 0;
   endtask

   // One cycle: drive at negedge, check combinational/registered outputs, then
   // advance the model across the rising edge.
   task automatic step(input logic [31:0] pci, input logic v, input logic [6:0] op,
                       input logic [31:0] rpc, input logic tk, input logic pd,
                       input logic rs);
      bit ev, e_clr, e_rst, e_pt;
      int idx;
      rst_n = rs; pc_if = pci; resolve_valid = v; resolve_opcode = op;
      resolve_pc = rpc; take_branch = tk; pred_in = pd;
      #1;
      ev    = v && (op == OP_BR);
      e_clr = ev && (tk != pd);
      e_rst = ev && pd && !tk;
      e_pt  = bht[pci[7:2]] >= 2;
      chk("predict_taken",    32'(pt_a),  32'(e_pt));
      chk("predict_taken_p4", 32'(pt_b),  32'(e_pt));
      chk("clear",            32'(clr_a), 32'(e_clr));
      chk("pc_restore",       32'(pr_a),  32'(e_rst));
      chk("branch_cnt",       32'(bc_a),  32'(sat(br_model, 65535)));
      chk("mispredict_cnt",   32'(mc_a),  32'(sat(mp_model, 65535)));
      chk("branch_cnt_p4",    32'(bc_b),  32'(sat(br_model, 15)));
      chk("mispredict_cnt_p4",32'(mc_b),  32'(sat(mp_model, 15)));
      @(posedge clk);
      if (!rs) model_reset();
      else if (ev) begin
         br_model++;
         if (e_clr) mp_model++;
         idx = int'(rpc[7:2]);
         if (tk) bht[idx] = (bht[idx] == 3) ? 3 : bht[idx] + 1;
         else    bht[idx] = (bht[idx] == 0) ? 0 : bht[idx] - 1;
      end
      @(negedge clk);
   endtask

   initial begin
      logic [6:0]  op;
      logic [31:0] a, b;
      checks = 0; errors = 0;
      rst_n = 1'b0; pc_if = '0; resolve_valid = 1'b0; resolve_opcode = OP_BR;
      resolve_pc = '0; take_branch = 1'b0; pred_in = 1'b0;
      @(posedge clk); @(negedge clk);
      model_reset();

      // Reset state: whole table weakly not-taken, counters zero.
      for (int i = 0; i < 64; i++) step(32'(i) << 2, 1'b0, OP_BR, 32'h0, 1'b0, 1'b0, 1'b1);

      // Three taken events at 0x40: first mispredicts, then counter saturates at 3.
      step(32'h40, 1'b1, OP_BR, 32'h40, 1'b1, 1'b0, 1'b1);
      step(32'h40, 1'b1, OP_BR, 32'h40, 1'b1, 1'b1, 1'b1);
      step(32'h40, 1'b1, OP_BR, 32'h40, 1'b1, 1'b1, 1'b1);
      step(32'h40, 1'b0, OP_BR, 32'h0,  1'b0, 1'b0, 1'b1);

      // Walk down from 3 with predicted-taken not-taken events, past saturation.
      for (int i = 0; i < 6; i++) step(32'h40, 1'b1, OP_BR, 32'h40, 1'b0, 1'b1, 1'b1);
      step(32'h40, 1'b1, OP_BR, 32'h40, 1'b1, 1'b0, 1'b1);
      step(32'h40, 1'b0, OP_BR, 32'h0,  1'b0, 1'b0, 1'b1);

      // Collision: no bypass on same-index read/write.
      step(32'h80, 1'b1, OP_BR, 32'h80, 1'b1, 1'b0, 1'b1);
      step(32'h80, 1'b0, OP_BR, 32'h0,  1'b0, 1'b0, 1'b1);

      // Non-events: JAL and invalid branch.
      step(32'h80, 1'b1, OP_JAL, 32'h80, 1'b0, 1'b1, 1'b1);
      step(32'h80, 1'b0, OP_BR,  32'h80, 1'b0, 1'b1, 1'b1);
      step(32'h80, 1'b0, OP_BR,  32'h0,  1'b0, 1'b0, 1'b1);

      // 20 mispredictions push the narrow statistics counter into saturation.
      for (int i = 0; i < 20; i++)
         step(32'h100, 1'b1, OP_BR, 32'h100 + (32'(i % 4) << 2), ~i[0], i[0], 1'b1);
      step(32'h100, 1'b0, OP_BR, 32'h0, 1'b0, 1'b0, 1'b1);

      // Reset during an event drops the update and restores the table.
      step(32'h40, 1'b1, OP_BR, 32'h80, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 64; i += 8) step(32'(i) << 2, 1'b0, OP_BR, 32'h0, 1'b0, 1'b0, 1'b1);

      // Random traffic over a small PC pool (with aliasing above bit 7).
      for (int n = 0; n < 400; n++) begin
         a = {22'($urandom_range(0, 3)), 4'($urandom_range(0, 7)), 2'b00, 4'h0} >> 2;
         b = {22'($urandom_range(0, 3)), 4'($urandom_range(0, 7)), 2'b00, 4'h0} >> 2;
         a = {a[29:0], 2'b00};
         b = {b[29:0], 2'b00};
         op = ($urandom_range(0, 4) == 0) ? OP_JAL : OP_BR;
         step(a, 1'($urandom_range(0, 3) != 0), op, b, 1'($urandom), 1'($urandom),
              1'($urandom_range(0, 59) != 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
